// File: rtl/demux_4_32_stream.sv
// demux_4_32_stream: steers one valid/ready stream into four registered output channels by in_sel
module demux_4_32_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out3_data,
  output logic             out3_valid,
  input  logic             out3_ready
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  logic [3:0] w_oready;
  logic [3:0] w_full;
  logic [3:0] w_load;
  logic       w_accept;
  assign w_oready = {out3_ready, out2_ready, out1_ready, out0_ready};
  // a full slot can still take a word in the same cycle its consumer drains it
  assign in_ready = ~w_full[in_sel] | w_oready[in_sel];
  assign w_accept = in_valid & in_ready;
  for (genvar n = 0; n < 4; n++) begin : g_ch
    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    assign w_load[n] = w_accept & (in_sel == 2'(n));
    assign w_full[n] = (r_state == FULL);
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= EMPTY;
      else        r_state <= w_next;
    end
    always_comb begin
      w_next = r_state;
      if (r_state == EMPTY) w_next = w_load[n] ? FULL : EMPTY;
      else                  w_next = (w_oready[n] & ~w_load[n]) ? EMPTY : FULL;
    end
    // data keeps its last word after a drain so outputs never go X
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)         r_data <= '0;
      else if (w_load[n]) r_data <= in_data;
    end
  end
  assign out0_data  = g_ch[0].r_data;
  assign out1_data  = g_ch[1].r_data;
  assign out2_data  = g_ch[2].r_data;
  assign out3_data  = g_ch[3].r_data;
  assign out0_valid = w_full[0];
  assign out1_valid = w_full[1];
  assign out2_valid = w_full[2];
  assign out3_valid = w_full[3];
endmodule

// File: tb/tb_demux_4_32_stream.sv
// tb_demux_4_32_stream: directed self-checking bench for demux_4_32_stream
module tb_demux_4_32_stream;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out0_data, out1_data, out2_data, out3_data;
  logic        out0_valid, out1_valid, out2_valid, out3_valid;
  logic        out0_ready = 1'b0, out1_ready = 1'b0, out2_ready = 1'b0, out3_ready = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  demux_4_32_stream #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .out3_data(out3_data), .out3_valid(out3_valid), .out3_ready(out3_ready)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    #2;
    n_cmp++; if ({out3_valid, out2_valid, out1_valid, out0_valid} !== 4'b0000) begin n_err++; $display("FAIL reset_valid: got %b want 0000", {out3_valid, out2_valid, out1_valid, out0_valid}); end
    n_cmp++; if ((out0_data | out1_data | out2_data | out3_data) !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h/%h/%h/%h want all 0", out0_data, out1_data, out2_data, out3_data); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if ({out3_valid, out2_valid, out1_valid, out0_valid} !== 4'b0000) begin n_err++; $display("FAIL release_valid: got %b want 0000", {out3_valid, out2_valid, out1_valid, out0_valid}); end
  endtask

  task automatic test_single();
    in_data = 32'hDEADBEEF; in_sel = 2'd2; in_valid = 1'b1; out2_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out2_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out2_valid); end
    n_cmp++; if (out2_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", out2_data); end
    n_cmp++; if ({out3_valid, out1_valid, out0_valid} !== 3'b000) begin n_err++; $display("FAIL single_others: got %b want 000", {out3_valid, out1_valid, out0_valid}); end
    @(negedge clk);
    n_cmp++; if (out2_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", out2_valid); end
    n_cmp++; if (out2_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_hold_after_drain: got %h want deadbeef", out2_data); end
    out2_ready = 1'b0;
  endtask

  task automatic test_stall();
    in_data = 32'h11; in_sel = 2'd1; in_valid = 1'b1;
    @(negedge clk);
    in_data = 32'h22;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out1_data !== 32'h11) begin n_err++; $display("FAIL stall_data: got %h want 11", out1_data); end
    @(negedge clk);
    n_cmp++; if (out1_data !== 32'h11 || out1_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold: got %h/%b want 11/1", out1_data, out1_valid); end
    in_data = 32'h33; in_sel = 2'd3;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_other_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out3_valid !== 1'b1 || out3_data !== 32'h33) begin n_err++; $display("FAIL stall_other_data: got %b/%h want 1/33", out3_valid, out3_data); end
    n_cmp++; if (out1_valid !== 1'b1 || out1_data !== 32'h11) begin n_err++; $display("FAIL stall_ch1_kept: got %b/%h want 1/11", out1_valid, out1_data); end
    out1_ready = 1'b1; out3_ready = 1'b1;
    @(negedge clk);
    out1_ready = 1'b0; out3_ready = 1'b0;
    n_cmp++; if ({out3_valid, out1_valid} !== 2'b00) begin n_err++; $display("FAIL stall_drain_both: got %b want 00", {out3_valid, out1_valid}); end
  endtask

  task automatic test_drain_load();
    in_data = 32'hA; in_sel = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    in_data = 32'hB; out0_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drain_load_ready: got %b want 1", in_ready); end
    n_cmp++; if (out0_data !== 32'hA) begin n_err++; $display("FAIL drain_load_first: got %h want a", out0_data); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out0_valid !== 1'b1 || out0_data !== 32'hB) begin n_err++; $display("FAIL drain_load_second: got %b/%h want 1/b", out0_valid, out0_data); end
    @(negedge clk);
    out0_ready = 1'b0;
    n_cmp++; if (out0_valid !== 1'b0) begin n_err++; $display("FAIL drain_load_empty: got %b want 0", out0_valid); end
  endtask

  task automatic test_back_to_back();
    out3_ready = 1'b1; in_sel = 2'd3; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'(i);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
      if (i > 0) begin
        n_cmp++; if (out3_valid !== 1'b1 || out3_data !== 32'(i - 1)) begin n_err++; $display("FAIL b2b_word[%0d]: got %b/%h want 1/%h", i - 1, out3_valid, out3_data, i - 1); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (out3_valid !== 1'b1 || out3_data !== 32'h7) begin n_err++; $display("FAIL b2b_word[7]: got %b/%h want 1/7", out3_valid, out3_data); end
    @(negedge clk);
    out3_ready = 1'b0;
    n_cmp++; if (out3_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", out3_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] words [4];
    words[0] = 32'hC0; words[1] = 32'hC1; words[2] = 32'hC2; words[3] = 32'hC3;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i); in_data = words[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if ({out3_valid, out2_valid, out1_valid, out0_valid} !== 4'b1111) begin n_err++; $display("FAIL mid_all_full: got %b want 1111", {out3_valid, out2_valid, out1_valid, out0_valid}); end
    n_cmp++; if (out0_data !== 32'hC0 || out1_data !== 32'hC1 || out2_data !== 32'hC2 || out3_data !== 32'hC3) begin n_err++; $display("FAIL mid_all_data: got %h/%h/%h/%h want c0/c1/c2/c3", out0_data, out1_data, out2_data, out3_data); end
    in_sel = 2'd2;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full_ready: got %b want 0", in_ready); end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++; if ({out3_valid, out2_valid, out1_valid, out0_valid} !== 4'b0000) begin n_err++; $display("FAIL mid_async_valid: got %b want 0000", {out3_valid, out2_valid, out1_valid, out0_valid}); end
    n_cmp++; if ((out0_data | out1_data | out2_data | out3_data) !== 32'h0) begin n_err++; $display("FAIL mid_async_data: got %h/%h/%h/%h want all 0", out0_data, out1_data, out2_data, out3_data); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_release_ready[%0d]: got %b want 1", i, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_drain_load();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
